// File: rtl/bsg_chip_pkg.sv
// Shared types for the bsg_chip command arbiter: requester source ids and the
// default order-FIFO depth.
package bsg_chip_pkg;

    typedef enum logic {
        e_src_mem = 1'b0,
        e_src_io  = 1'b1
    } bsg_chip_cmd_src_e;

    localparam int bsg_chip_cmd_els_gp = 8;

endpackage

// File: rtl/bsg_chip_cmd_order_fifo.sv
// Circular FIFO of source ids, one entry per outstanding link command.
// Depth must be a power of two so the pointers wrap on their own.
module bsg_chip_cmd_order_fifo
    import bsg_chip_pkg::*;
#(
    parameter int els_p = bsg_chip_cmd_els_gp
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  bsg_chip_cmd_src_e            data_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    output bsg_chip_cmd_src_e            data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_width_lp = $clog2(els_p);
    localparam int cnt_width_lp = $clog2(els_p + 1);

    logic [els_p-1:0]        slot_reg;
    logic [els_p-1:0]        slot_we;
    logic [ptr_width_lp-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [cnt_width_lp-1:0] count_reg, count_next;
    logic                    push_ok, pop_ok;

    assign full_o  = (count_reg == cnt_width_lp'(els_p));
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    for (genvar gi = 0; gi < els_p; gi++) begin : g_slot_we
        assign slot_we[gi] = push_ok & (wr_ptr_reg == ptr_width_lp'(gi));
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < els_p; i++) begin
            if (slot_we[i]) slot_reg[i] <= data_i;
        end
    end

    assign data_o = bsg_chip_cmd_src_e'(slot_reg[rd_ptr_reg]);

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok)      count_next = count_reg + 1'b1;
        else if (!push_ok && pop_ok) count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/bsg_chip_cmd_arbiter.sv
// Arbitrates mem/io command streams onto one link and steers in-order responses
// back by source. Define BSG_CHIP_CMD_ARB_IO_PRIORITY_EN for fixed io priority.
module bsg_chip_cmd_arbiter
    import bsg_chip_pkg::*;
#(
    parameter int msg_width_p = 128,
    parameter int els_p       = bsg_chip_cmd_els_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [msg_width_p-1:0]      mem_cmd_i,
    input  logic                        mem_cmd_v_i,
    output logic                        mem_cmd_ready_o,
    input  logic [msg_width_p-1:0]      io_cmd_i,
    input  logic                        io_cmd_v_i,
    output logic                        io_cmd_ready_o,
    output logic [msg_width_p-1:0]      link_cmd_o,
    output logic                        link_cmd_v_o,
    input  logic                        link_cmd_ready_i,
    input  logic [msg_width_p-1:0]      link_resp_i,
    input  logic                        link_resp_v_i,
    output logic                        link_resp_yumi_o,
    output logic [msg_width_p-1:0]      mem_resp_o,
    output logic                        mem_resp_v_o,
    input  logic                        mem_resp_yumi_i,
    output logic [msg_width_p-1:0]      io_resp_o,
    output logic                        io_resp_v_o,
    input  logic                        io_resp_yumi_i,
    output logic [$clog2(els_p+1)-1:0]  outstanding_o,
    output logic                        error_o
);

    logic                   fifo_full, fifo_empty;
    bsg_chip_cmd_src_e      fifo_head, push_src;
    logic                   can_accept, mem_win, io_win;
    logic                   mem_accept, io_accept, accept;
    logic                   link_cmd_v_reg, error_reg;
    logic [msg_width_p-1:0] link_cmd_reg;

    assign can_accept = ~fifo_full & (~link_cmd_v_reg | link_cmd_ready_i);

    // Each side's ready asks "would I win if I were valid", so it never
    // looks at its own valid.
`ifdef BSG_CHIP_CMD_ARB_IO_PRIORITY_EN
    assign io_win  = 1'b1;
    assign mem_win = ~io_cmd_v_i;
`else
    bsg_chip_cmd_src_e last_grant_reg;

    assign mem_win = ~io_cmd_v_i  | (last_grant_reg == e_src_io);
    assign io_win  = ~mem_cmd_v_i | (last_grant_reg == e_src_mem);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)  last_grant_reg <= e_src_io;
        else if (accept) last_grant_reg <= push_src;
    end
`endif

    assign mem_cmd_ready_o = reset_n_i & can_accept & mem_win;
    assign io_cmd_ready_o  = reset_n_i & can_accept & io_win;
    assign mem_accept      = mem_cmd_v_i & mem_cmd_ready_o;
    assign io_accept       = io_cmd_v_i & io_cmd_ready_o;
    assign accept          = mem_accept | io_accept;
    assign push_src        = io_accept ? e_src_io : e_src_mem;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)             link_cmd_v_reg <= 1'b0;
        else if (accept)            link_cmd_v_reg <= 1'b1;
        else if (link_cmd_ready_i)  link_cmd_v_reg <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (accept) link_cmd_reg <= io_accept ? io_cmd_i : mem_cmd_i;
    end

    assign link_cmd_o   = link_cmd_reg;
    assign link_cmd_v_o = link_cmd_v_reg;

    bsg_chip_cmd_order_fifo #(.els_p(els_p)) order_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (push_src),
        .push_i    (accept),
        .pop_i     (link_resp_yumi_o),
        .data_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (outstanding_o)
    );

    // With nothing outstanding the response is dropped so the link never wedges.
    always_comb begin
        mem_resp_v_o     = 1'b0;
        io_resp_v_o      = 1'b0;
        link_resp_yumi_o = link_resp_v_i;
        if (!fifo_empty) begin
            if (fifo_head == e_src_mem) begin
                mem_resp_v_o     = link_resp_v_i;
                link_resp_yumi_o = mem_resp_yumi_i;
            end else begin
                io_resp_v_o      = link_resp_v_i;
                link_resp_yumi_o = io_resp_yumi_i;
            end
        end
    end

    assign mem_resp_o = link_resp_i;
    assign io_resp_o  = link_resp_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) error_reg <= 1'b0;
        else            error_reg <= error_reg | (link_resp_v_i & fifo_empty);
    end

    assign error_o = error_reg;

endmodule

// File: tb/tb_bsg_chip_cmd_arbiter.sv
// Self-checking bench for bsg_chip_cmd_arbiter: vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_bsg_chip_cmd_arbiter;

    localparam int MSG = 16;
    localparam int ELS = 8;
    localparam int CW  = $clog2(ELS + 1);
`ifdef BSG_CHIP_CMD_ARB_IO_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic           clk, rst_n;
    logic [MSG-1:0] mem_cmd, io_cmd, link_cmd, link_resp, mem_resp, io_resp;
    logic           mem_v, mem_ready, io_v, io_ready, link_v, link_ready;
    logic           resp_v, resp_yumi, mem_resp_v, mem_yumi, io_resp_v, io_yumi;
    logic [CW-1:0]  outstanding;
    logic           error;

    int checks   = 0;
    int failures = 0;

    bsg_chip_cmd_arbiter #(.msg_width_p(MSG), .els_p(ELS)) dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .mem_cmd_i        (mem_cmd),
        .mem_cmd_v_i      (mem_v),
        .mem_cmd_ready_o  (mem_ready),
        .io_cmd_i         (io_cmd),
        .io_cmd_v_i       (io_v),
        .io_cmd_ready_o   (io_ready),
        .link_cmd_o       (link_cmd),
        .link_cmd_v_o     (link_v),
        .link_cmd_ready_i (link_ready),
        .link_resp_i      (link_resp),
        .link_resp_v_i    (resp_v),
        .link_resp_yumi_o (resp_yumi),
        .mem_resp_o       (mem_resp),
        .mem_resp_v_o     (mem_resp_v),
        .mem_resp_yumi_i  (mem_yumi),
        .io_resp_o        (io_resp),
        .io_resp_v_o      (io_resp_v),
        .io_resp_yumi_i   (io_yumi),
        .outstanding_o    (outstanding),
        .error_o          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit mv, iv, lr, rv, my, iy;
        bit e_mr, e_ir, e_lv, e_mrv, e_irv, e_yumi, e_err;
        int e_out;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_v = 0; io_v = 0; link_ready = 1; resp_v = 0; mem_yumi = 0; io_yumi = 0;
        mem_cmd = '0; io_cmd = '0; link_resp = '0;
    endtask

    task automatic do_reset();
        idle();
        mem_v = 1; io_v = 1;
        rst_n = 0;
        #1;
        check("reset_link_v", link_v, 0);
        check("reset_outstanding", outstanding, 0);
        check("reset_error", error, 0);
        check("reset_mem_ready", mem_ready, 0);
        check("reset_io_ready", io_ready, 0);
        check("reset_resp_v", {mem_resp_v, io_resp_v}, 0);
        repeat (2) @(posedge clk);
        #1;
        idle();
        rst_n = 1;
        $display("reset released");
    endtask

    // Reference arbitration: 0 = mem wins, 1 = io wins, 2 = nobody requesting.
    function automatic int winner(bit m, bit i, bit last_io);
        if (PRIO) return i ? 1 : (m ? 0 : 2);
        if (m && i) return last_io ? 0 : 1;
        if (m) return 0;
        if (i) return 1;
        return 2;
    endfunction

    initial begin
        rst_n = 1;
        idle();

        //              mv iv lr rv my iy  mr    ir    lv mrv   irv   y  err out
        vecs[0]  = '{1, 1, 1, 0, 0, 0, !PRIO, PRIO, 0, 0,    0,    0, 0, 0};
        vecs[1]  = '{1, 1, 1, 0, 0, 0, 0,     1,    1, 0,    0,    0, 0, 1};
        vecs[2]  = '{1, 1, 1, 0, 0, 0, !PRIO, PRIO, 1, 0,    0,    0, 0, 2};
        vecs[3]  = '{1, 1, 1, 0, 0, 0, 0,     1,    1, 0,    0,    0, 0, 3};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,     0,    1, 0,    0,    0, 0, 4};
        vecs[5]  = '{0, 0, 1, 1, 1, 1, 1,     1,    1, !PRIO, PRIO, 1, 0, 4};
        vecs[6]  = '{0, 0, 1, 1, 0, 0, 1,     1,    0, 0,    1,    0, 0, 3};
        vecs[7]  = '{0, 0, 1, 1, 0, 1, 1,     1,    0, 0,    1,    1, 0, 3};
        vecs[8]  = '{0, 0, 1, 1, 1, 1, 1,     1,    0, !PRIO, PRIO, 1, 0, 2};
        vecs[9]  = '{0, 0, 1, 1, 1, 1, 1,     1,    0, 0,    1,    1, 0, 1};
        vecs[10] = '{0, 0, 1, 1, 0, 0, 1,     1,    0, 0,    0,    1, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 0, 0, 1,     1,    0, 0,    0,    0, 1, 0};

        #3;
        do_reset();

        // Vector table: grants, stall, in-order steering, spurious response.
        for (int r = 0; r < 12; r++) begin
            mem_v = vecs[r].mv; io_v = vecs[r].iv; link_ready = vecs[r].lr;
            resp_v = vecs[r].rv; mem_yumi = vecs[r].my; io_yumi = vecs[r].iy;
            mem_cmd = MSG'(16'hA000 + r); io_cmd = MSG'(16'hB000 + r);
            link_resp = MSG'(16'hC000 + r);
            #1;
            check($sformatf("vec%0d_mem_ready", r), mem_ready, vecs[r].e_mr);
            check($sformatf("vec%0d_io_ready", r), io_ready, vecs[r].e_ir);
            check($sformatf("vec%0d_link_v", r), link_v, vecs[r].e_lv);
            check($sformatf("vec%0d_mem_resp_v", r), mem_resp_v, vecs[r].e_mrv);
            check($sformatf("vec%0d_io_resp_v", r), io_resp_v, vecs[r].e_irv);
            check($sformatf("vec%0d_yumi", r), resp_yumi, vecs[r].e_yumi);
            check($sformatf("vec%0d_error", r), error, vecs[r].e_err);
            check($sformatf("vec%0d_outstanding", r), outstanding, vecs[r].e_out);
            $display("vec %0d mem_ready=%0d io_ready=%0d outstanding=%0d", r, mem_ready, io_ready, outstanding);
            cyc();
        end

        // Mem-only stream A,B,C with the link always ready.
        do_reset();
        mem_v = 1; mem_cmd = 16'h0A0A;
        #1 check("abc_ready", mem_ready, 1);
        cyc(); mem_cmd = 16'h0B0B;
        #1 check("abc_a", link_cmd, 16'h0A0A); check("abc_v1", link_v, 1); check("abc_out1", outstanding, 1);
        cyc(); mem_cmd = 16'h0C0C;
        #1 check("abc_b", link_cmd, 16'h0B0B); check("abc_out2", outstanding, 2);
        cyc(); mem_v = 0;
        #1 check("abc_c", link_cmd, 16'h0C0C); check("abc_out3", outstanding, 3);
        cyc();
        #1 check("abc_drained", link_v, 0);
        $display("seq abc done");

        // Link stalled for 5 cycles: command held, next accepted as ready rises.
        do_reset();
        link_ready = 0; mem_v = 1; mem_cmd = 16'h0D0D;
        cyc(); mem_cmd = 16'h0E0E;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_data", link_cmd, 16'h0D0D);
            check("stall_v", link_v, 1);
            check("stall_ready", mem_ready, 0);
            cyc();
        end
        link_ready = 1;
        #1 check("stall_release_ready", mem_ready, 1);
        cyc(); mem_v = 0;
        #1 check("stall_next_data", link_cmd, 16'h0E0E); check("stall_out", outstanding, 2);
        $display("seq stall done");

        // Fill to els_p outstanding, then free exactly one slot.
        do_reset();
        mem_v = 1;
        for (int k = 0; k < ELS; k++) begin
            mem_cmd = MSG'(k);
            cyc();
        end
        io_v = 1;
        #1 check("full_out", outstanding, ELS); check("full_mem_ready", mem_ready, 0); check("full_io_ready", io_ready, 0);
        resp_v = 1; mem_yumi = 1; io_yumi = 1;
        #1 check("full_pop_yumi", resp_yumi, 1); check("full_pop_blocks_push", {mem_ready, io_ready}, 0);
        cyc(); resp_v = 0; mem_yumi = 0; io_yumi = 0; io_v = 0;
        #1 check("full_freed_out", outstanding, ELS - 1); check("full_freed_ready", mem_ready, 1);
        cyc(); mem_v = 0;
        #1 check("full_refill_out", outstanding, ELS); check("full_refill_ready", mem_ready, 0);
        $display("seq full done");

        // Mid-stream reset, then spurious response and sticky error.
        do_reset();
        link_ready = 0; mem_v = 1; mem_cmd = 16'h0F0F;
        cyc(); mem_v = 0;
        #1 check("mid_out_before", outstanding, 1);
        rst_n = 0;
        #1 check("mid_out_cleared", outstanding, 0); check("mid_link_v_cleared", link_v, 0);
        cyc(); rst_n = 1; link_ready = 1;
        resp_v = 1; link_resp = 16'h5A5A;
        #1 check("spur_yumi", resp_yumi, 1); check("spur_resp_v", {mem_resp_v, io_resp_v}, 0);
        cyc(); resp_v = 0;
        #1 check("spur_error", error, 1);
        repeat (3) cyc();
        check("spur_error_sticky", error, 1);
        rst_n = 0;
        #1 check("spur_error_reset", error, 0);
        cyc(); rst_n = 1;
        $display("seq spurious done");

        // Randomized run against a queue-based model.
        do_reset();
        begin
            bit             q[$];
            bit             m_ov = 0, m_last_io = 1, m_err = 0;
            logic [MSG-1:0] m_od = '0;
            bit             can, e_mr, e_ir, e_mrv, e_irv, e_y, was_empty;
            int             w;
            for (int c = 0; c < 400; c++) begin
                mem_v = 1'($urandom_range(0, 1));
                io_v = 1'($urandom_range(0, 1));
                link_ready = ($urandom_range(0, 3) != 0);
                resp_v = 1'($urandom_range(0, 1));
                mem_yumi = resp_v & ($urandom_range(0, 9) < 7);
                io_yumi = resp_v & ($urandom_range(0, 9) < 7);
                mem_cmd = MSG'($urandom); io_cmd = MSG'($urandom); link_resp = MSG'($urandom);
                #1;
                can  = (q.size() < ELS) && (!m_ov || link_ready);
                e_mr = can && (winner(1'b1, io_v, m_last_io) == 0);
                e_ir = can && (winner(mem_v, 1'b1, m_last_io) == 1);
                was_empty = (q.size() == 0);
                if (was_empty) begin
                    e_mrv = 0; e_irv = 0; e_y = resp_v;
                end else if (q[0] == 1'b0) begin
                    e_mrv = resp_v; e_irv = 0; e_y = mem_yumi;
                end else begin
                    e_mrv = 0; e_irv = resp_v; e_y = io_yumi;
                end
                check("rnd_mem_ready", mem_ready, e_mr);
                check("rnd_io_ready", io_ready, e_ir);
                check("rnd_link_v", link_v, m_ov);
                if (m_ov) check("rnd_link_cmd", link_cmd, m_od);
                check("rnd_mem_resp_v", mem_resp_v, e_mrv);
                check("rnd_io_resp_v", io_resp_v, e_irv);
                check("rnd_yumi", resp_yumi, e_y);
                check("rnd_outstanding", outstanding, q.size());
                check("rnd_error", error, m_err);
                if (e_mrv) check("rnd_mem_resp", mem_resp, link_resp);
                if (e_irv) check("rnd_io_resp", io_resp, link_resp);

                if (resp_v && was_empty) m_err = 1;
                if (e_y && !was_empty) void'(q.pop_front());
                w = winner(mem_v, io_v, m_last_io);
                if (can && w != 2) begin
                    q.push_back(w == 1);
                    m_ov = 1;
                    m_od = (w == 1) ? io_cmd : mem_cmd;
                    m_last_io = (w == 1);
                    $display("rnd cycle %0d accept src=%s data=%0h outstanding_next=%0d",
                             c, (w == 1) ? "io" : "mem", m_od, q.size());
                end else if (link_ready) begin
                    m_ov = 0;
                end
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_chip_cmd_arbiter.md
Name: bsg_chip_cmd_arbiter

Overview:
- Shares one off-chip command/response link between the core's two outbound command streams: memory commands and I/O commands.
- Round-robin arbitration for commands; a source-order FIFO steers in-order responses back to the requester that issued each command.
- Sits in bsg_chip between the softcore's mem_cmd/io_cmd ports and the link.

Parameters:
- msg_width_p, 128: width of one command/response message (cce_mem_msg_width_lp at instantiation).
- els_p, 8: maximum outstanding commands (order-FIFO depth); power of two, at least 2.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- mem_cmd_i  in  msg_width_p  memory command from core
- mem_cmd_v_i  in  1  memory command valid
- mem_cmd_ready_o  out  1  memory command accepted when v&ready
- io_cmd_i  in  msg_width_p  I/O command from core
- io_cmd_v_i  in  1  I/O command valid
- io_cmd_ready_o  out  1  I/O command accepted when v&ready
- link_cmd_o  out  msg_width_p  registered command to link
- link_cmd_v_o  out  1  link command valid
- link_cmd_ready_i  in  1  link accepts when v&ready
- link_resp_i  in  msg_width_p  response from link
- link_resp_v_i  in  1  response valid
- link_resp_yumi_o  out  1  response consumed
- mem_resp_o  out  msg_width_p  response to memory requester
- mem_resp_v_o  out  1  memory response valid
- mem_resp_yumi_i  in  1  memory requester consumes
- io_resp_o  out  msg_width_p  response to I/O requester
- io_resp_v_o  out  1  I/O response valid
- io_resp_yumi_i  in  1  I/O requester consumes
- outstanding_o  out  $clog2(els_p+1)  commands issued, responses not yet returned
- error_o  out  1  sticky: response arrived with no outstanding command

Behaviour:
- Reset (async assert, sync release): link_cmd_v_o=0, outstanding_o=0, error_o=0, order FIFO empty, last_grant=io so mem wins the first tie; all ready/valid outputs 0.
- can_accept = order FIFO not full AND (output register empty OR link_cmd_ready_i).
- Grant, combinational: a single valid requester wins; both valid -> the one not equal to last_grant. mem_cmd_ready_o = can_accept & (grant==mem), io likewise. Ready may depend on the other requester's valid; it never depends on its own valid.
- On accept: load output register next edge (1-cycle latency to link_cmd_v_o), push source id, update last_grant. Output register holds data stable while link_cmd_v_o & ~link_cmd_ready_i.
- Back-to-back: full throughput, one command per cycle when link_cmd_ready_i=1.
- Responses are in order. Head of the FIFO selects the destination:
  - head=mem: mem_resp_v_o = link_resp_v_i & ~empty; io_resp_v_o=0; link_resp_yumi_o = mem_resp_yumi_i.
  - head=io: symmetric.
  - Response data is forwarded combinationally to both resp outputs.
- Pop on link_resp_yumi_o.
- Spurious response (link_resp_v_i while FIFO empty): link_resp_yumi_o=1 (drop, avoids deadlock); error_o set until reset.
- Push and pop in the same cycle: both occur, count unchanged. At full, push is blocked even when a pop occurs in that cycle.
- outstanding_o equals the FIFO count. It increments at command accept (not link acceptance), so it can reach els_p.
- Reset mid-operation: in-flight command and all outstanding tags are discarded; later responses for them count as spurious.

Optional Feature:
- Macro BSG_CHIP_CMD_ARB_IO_PRIORITY_EN.
- Defined: fixed priority. io wins whenever io_cmd_v_i=1; last_grant is not used.
- Undefined: round-robin as above.
- Response steering is identical in both modes.

Decomposition:
- bsg_chip_pkg: enum bsg_chip_cmd_src_e {e_src_mem=1'b0, e_src_io=1'b1}; default els constant.
- Sub-module bsg_chip_cmd_order_fifo: 1-bit-wide, els_p-deep circular FIFO. Provides full/empty/count, wrap-around pointers, and an async active-low reset.

Test Plan:
- Only mem valid, 3 commands A,B,C, link ready: link_cmd_o shows A,B,C on cycles 1,2,3; outstanding_o goes 1,2,3.
- Both valid continuously for 4 cycles: grants mem,io,mem,io. With IO_PRIORITY_EN defined: io,io,io,io.
- Link ready low for 5 cycles with one command: link_cmd_o stable and v held. Next command accepted in the cycle link_cmd_ready_i rises.
- Issue mem,io,mem, then 3 responses R0,R1,R2: mem_resp_v_o for R0, io_resp_v_o for R1, mem_resp_v_o for R2; outstanding returns to 0. Holding io_resp_yumi_i=0 stalls R1 and link_resp_yumi_o=0.
- 8 commands with no responses (els_p=8): both ready=0 and outstanding_o=8. One response frees exactly one slot next cycle.
- Response with FIFO empty: yumi=1 same cycle, error_o=1 until reset_n_i is asserted low. Mid-stream reset clears outstanding_o to 0 immediately.
